core_run_monitor: RTL
=====================

CORE_RUN_MONITOR -- requirements
Module: core_run_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/pc width.
REQ-002 SHALL have parameter NREGS, default 32, register-file entries presented on regs.
REQ-003 SHALL have parameter DUMP_REGS, default 16, entries streamed out after a run, 1..NREGS.
REQ-004 SHALL have parameter CNT_W, default 32, width of all counters.
REQ-005 SHALL have parameter MAX_CYCLES, default 8450, run-cycle limit before timeout, 1..2^CNT_W-1.
REQ-006 Ports (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous reset, active-high
  start  in  1  begin a run; accepted only in IDLE or DONE
  completed  in  1  core finished flag
  pc  in  XLEN  core program counter
  pred_valid  in  1  branch prediction resolved this cycle
  pred_hit  in  1  resolved prediction was correct (qualified by pred_valid)
  regs  in  NREGS*XLEN  flattened register file, entry r at bits [r*XLEN +: XLEN]
  dump_ready  in  1  sink accepts dump beat
  busy  out  1  state is RUN or DUMP
  done  out  1  state is DONE
  timeout  out  1  last run ended by cycle limit
  cycles  out  CNT_W  RUN cycles of last/current run
  final_pc  out  XLEN  pc captured at run end
  pred_total/pred_succ/pred_fail  out  CNT_W each  prediction counters
  dump_valid  out  1  dump beat valid
  dump_idx  out  $clog2(NREGS)  register index of beat
  dump_data  out  XLEN  register value of beat
  dump_last  out  1  final beat (dump_idx == DUMP_REGS-1)

Function
REQ-007 SHALL implement FSM IDLE -> RUN -> DUMP -> DONE; DONE -> RUN on start.
REQ-008 IDLE/DONE with start=1 SHALL enter RUN next cycle and clear cycles, pred_*, timeout, final_pc to 0 in the same edge.
REQ-009 start SHALL be ignored in RUN and DUMP.
REQ-010 Each RUN cycle SHALL increment cycles by 1; cycles counts the ending cycle too (completed in first RUN cycle -> cycles=1).
REQ-011 Each RUN cycle with pred_valid=1 SHALL increment pred_total and exactly one of pred_succ (pred_hit=1) or pred_fail (pred_hit=0); pred_* SHALL not change outside RUN.
REQ-012 All counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-013 RUN with completed=1 SHALL end the run: latch final_pc<=pc, snapshot regs entries 0..DUMP_REGS-1 into internal storage, timeout<=0, go DUMP.
REQ-014 RUN with completed=0 and cycles+1 == MAX_CYCLES SHALL end the run identically but with timeout<=1.
REQ-015 completed=1 on the limit cycle SHALL take precedence: timeout=0.
REQ-016 DUMP SHALL hold dump_valid=1, dump_idx starting at 0, dump_data = snapshot[dump_idx]; beat transfers when dump_valid & dump_ready.
REQ-017 On transfer with dump_last=0 dump_idx SHALL increment; with dump_last=1 SHALL go DONE, dump_valid=0 next cycle.
REQ-018 dump_valid/idx/data/last SHALL remain stable while dump_valid=1 and dump_ready=0.
REQ-019 Dump data SHALL come only from snapshot; regs changes after run end SHALL not affect it.
REQ-020 cycles, final_pc, timeout, pred_* SHALL hold in DUMP and DONE until next accepted start.
REQ-021 dump_valid SHALL be 0 outside DUMP; dump_idx/dump_data/dump_last SHALL be 0 when dump_valid=0.

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE and all outputs 0, overriding start and any in-progress run or dump.
REQ-023 rst mid-DUMP SHALL drop dump_valid the next cycle; no further beats emitted.

Verification
REQ-024 start, completed=1 on RUN cycle 100, pc=0x1F4, 40 pred_valid (30 hit) -> cycles=100, final_pc=0x1F4, pred 40/30/10, timeout=0, 16 beats idx 0..15 then done=1.
REQ-025 MAX_CYCLES=8, completed never -> timeout=1, cycles=8, dump follows, done=1.
REQ-026 MAX_CYCLES=8, completed=1 on RUN cycle 8 -> timeout=0, cycles=8.
REQ-027 dump_ready toggled 1/0 each cycle, regs altered during DUMP -> every beat stable while stalled, data equals values at run end, 16 beats total.
REQ-028 CNT_W=4, pred_valid=1 for 20 RUN cycles, all hit -> pred_total=pred_succ=15, pred_fail=0; start during RUN ignored.
REQ-029 rst asserted at dump beat 5 -> IDLE next cycle, all outputs 0; new start runs cleanly from cycles=0.

Source files
------------

// File: rtl/core_run_monitor.sv
// rtl/core_run_monitor.sv - run monitor: counts cycles/predictions of a core run, then streams a register snapshot
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   start                         begin a run (honoured only when idle or done)
//   completed, pc                 core finished flag and program counter
//   pred_valid, pred_hit          branch prediction resolution strobe and outcome
//   regs                          flattened register file, entry r at [r*XLEN +: XLEN]
//   busy, done, timeout           status of the current/last run
//   cycles, final_pc              run length and pc captured at run end
//   pred_total/succ/fail          prediction counters
//   dump_valid/ready/idx/data/last  snapshot stream, one register per beat
module core_run_monitor #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int DUMP_REGS  = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 8450
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     completed,
  input  logic [XLEN-1:0]          pc,
  input  logic                     pred_valid,
  input  logic                     pred_hit,
  input  logic [NREGS*XLEN-1:0]    regs,
  input  logic                     dump_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [CNT_W-1:0]         cycles,
  output logic [XLEN-1:0]          final_pc,
  output logic [CNT_W-1:0]         pred_total,
  output logic [CNT_W-1:0]         pred_succ,
  output logic [CNT_W-1:0]         pred_fail,
  output logic                     dump_valid,
  output logic [$clog2(NREGS)-1:0] dump_idx,
  output logic [XLEN-1:0]          dump_data,
  output logic                     dump_last
);

  localparam int IW = $clog2(NREGS);
  localparam int SW = (DUMP_REGS > 1) ? $clog2(DUMP_REGS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   LIMIT    = (CNT_W+1)'(MAX_CYCLES);
  localparam logic [IW-1:0]    LAST_IDX = IW'(DUMP_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DUMP, S_DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] snap [DUMP_REGS];
  logic [CNT_W:0]  cyc_next;
  logic            run_end;
  logic [IW-1:0]   nxt_idx;

  // Only the first DUMP_REGS entries are captured; the rest are ignored.
  logic unused_regs_bits;
  assign unused_regs_bits = ^regs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // One bit wider so the limit compare cannot alias on a saturated counter.
  assign cyc_next = {1'b0, cycles} + (CNT_W+1)'(1);
  // completed wins over the limit; both end the run on the same edge.
  assign run_end  = completed || (cyc_next == LIMIT);
  assign nxt_idx  = dump_idx + IW'(1);

  assign busy = (state == S_RUN) || (state == S_DUMP);
  assign done = (state == S_DONE);

  // Snapshot storage needs no reset: it is only read during DUMP, which is
  // always preceded by a capture.
  always_ff @(posedge clk) begin
    if (state == S_RUN && run_end) begin
      for (int i = 0; i < DUMP_REGS; i++) begin
        snap[i] <= regs[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timeout    <= 1'b0;
      cycles     <= '0;
      final_pc   <= '0;
      pred_total <= '0;
      pred_succ  <= '0;
      pred_fail  <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            timeout    <= 1'b0;
            cycles     <= '0;
            final_pc   <= '0;
            pred_total <= '0;
            pred_succ  <= '0;
            pred_fail  <= '0;
          end
        end
        S_RUN: begin
          cycles <= sat_inc(cycles);
          if (pred_valid) begin
            pred_total <= sat_inc(pred_total);
            if (pred_hit) pred_succ <= sat_inc(pred_succ);
            else          pred_fail <= sat_inc(pred_fail);
          end
          if (run_end) begin
            state      <= S_DUMP;
            final_pc   <= pc;
            timeout    <= ~completed;
            // First beat comes straight from regs; it equals what snap captures.
            dump_valid <= 1'b1;
            dump_idx   <= '0;
            dump_data  <= regs[XLEN-1:0];
            dump_last  <= (DUMP_REGS == 1);
          end
        end
        S_DUMP: begin
          if (dump_ready) begin
            if (dump_last) begin
              state      <= S_DONE;
              dump_valid <= 1'b0;
              dump_idx   <= '0;
              dump_data  <= '0;
              dump_last  <= 1'b0;
            end else begin
              dump_idx  <= nxt_idx;
              dump_data <= snap[nxt_idx[SW-1:0]];
              dump_last <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
